// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: DrawX/DrawY counters, blank/line/frame decodes,
// and active-low hs/vs delayed SYNC_DELAY cycles to stay aligned with renderer colour.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic       hs,
    output logic       vs,
    output logic [7:0] frame_count
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HMax = 10'(H_TOTAL - 1);
    localparam logic [9:0] VMax = 10'(V_TOTAL - 1);

    // 11-bit bounds so a boundary equal to 1024 still compares correctly
    localparam logic [10:0] HActive  = 11'(H_ACTIVE);
    localparam logic [10:0] VActive  = 11'(V_ACTIVE);
    localparam logic [10:0] HSyncLo  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncHi  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VSyncLo  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSyncHi  = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
    end

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [7:0] fc_q, fc_d;
    logic       hs_raw, vs_raw;

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        fc_d = fc_q;
        if (hc_q == HMax) begin
            hc_d = '0;
            if (vc_q == VMax) begin
                vc_d = '0;
                fc_d = fc_q + 8'd1;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q <= '0;
            vc_q <= '0;
            fc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            fc_q <= fc_d;
        end
    end

    always_comb begin
        blank       = ({1'b0, hc_q} < HActive) && ({1'b0, vc_q} < VActive);
        line_start  = (hc_q == 10'd0);
        frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
        hs_raw      = !(({1'b0, hc_q} >= HSyncLo) && ({1'b0, hc_q} < HSyncHi));
        vs_raw      = !(({1'b0, vc_q} >= VSyncLo) && ({1'b0, vc_q} < VSyncHi));
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign frame_count = fc_q;

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hs = hs_raw;
        assign vs = vs_raw;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
        logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

        always_comb begin
            hs_pipe_d[0] = hs_raw;
            vs_pipe_d[0] = vs_raw;
            for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
                hs_pipe_d[i] = hs_pipe_q[i-1];
                vs_pipe_d[i] = vs_pipe_q[i-1];
            end
        end

        // Flushing to idle-high keeps a reset from leaving a truncated sync pulse in flight
        always_ff @(posedge vga_clk) begin
            if (reset) begin
                hs_pipe_q <= '1;
                vs_pipe_q <= '1;
            end else begin
                hs_pipe_q <= hs_pipe_d;
                vs_pipe_q <= vs_pipe_d;
            end
        end

        assign hs = hs_pipe_q[SYNC_DELAY-1];
        assign vs = vs_pipe_q[SYNC_DELAY-1];
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default raster (D=2), tiny raster (D=0) and
// tiny raster with D=2 used for the reset-during-sync case.
module tb_vga_timing_gen;
    localparam int unsigned NCYC = 28784;  // 257 tiny frames of 112 cycles

    localparam int unsigned HA  [3] = '{640, 8, 8};
    localparam int unsigned HFP [3] = '{16, 2, 2};
    localparam int unsigned HSY [3] = '{96, 4, 4};
    localparam int unsigned HBP [3] = '{48, 2, 2};
    localparam int unsigned VA  [3] = '{480, 4, 4};
    localparam int unsigned VFP [3] = '{10, 1, 1};
    localparam int unsigned VSY [3] = '{2, 1, 1};
    localparam int unsigned VBP [3] = '{33, 1, 1};
    localparam int unsigned DL  [3] = '{2, 0, 2};

    string inst_name [3] = '{"def", "tiny", "mid"};
    string sig_name  [8] = '{"DrawX", "DrawY", "blank", "line_start", "frame_start",
                             "hs", "vs", "frame_count"};

    logic       clk;
    logic       rst [3];
    logic [9:0] dx [3];
    logic [9:0] dy [3];
    logic       bl [3];
    logic       ls [3];
    logic       fs [3];
    logic       hs_o [3];
    logic       vs_o [3];
    logic [7:0] fc [3];

    typedef struct packed {
        int unsigned cyc;
        int unsigned inst;
        int unsigned sig;
        int unsigned exp;
    } exp_t;

    exp_t        exp_q [$];
    int unsigned ncyc;
    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned mx [3];
    int unsigned my [3];
    int unsigned mfc [3];
    int unsigned tiny_fs, tiny_blank, tiny_hs_lo, tiny_vs_lo;
    bit          def_done, mid_done;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset(rst[0]), .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .hs(hs_o[0]), .vs(vs_o[0]),
        .frame_count(fc[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(0)
    ) u_tiny (
        .vga_clk(clk), .reset(rst[1]), .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .hs(hs_o[1]), .vs(vs_o[1]),
        .frame_count(fc[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(2)
    ) u_mid (
        .vga_clk(clk), .reset(rst[2]), .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .hs(hs_o[2]), .vs(vs_o[2]),
        .frame_count(fc[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int unsigned actual(int unsigned i, int unsigned s);
        case (s)
            0:       return 32'(dx[i]);
            1:       return 32'(dy[i]);
            2:       return 32'(bl[i]);
            3:       return 32'(ls[i]);
            4:       return 32'(fs[i]);
            5:       return 32'(hs_o[i]);
            6:       return 32'(vs_o[i]);
            default: return 32'(fc[i]);
        endcase
    endfunction

    // Syncs are the raw windows shifted D cycles later; none of these windows wrap.
    function automatic int unsigned exp_val(int unsigned i, int unsigned s);
        int unsigned ht  = HA[i] + HFP[i] + HSY[i] + HBP[i];
        int unsigned p   = my[i] * ht + mx[i];
        int unsigned hlo = HA[i] + HFP[i] + DL[i];
        int unsigned vlo = (VA[i] + VFP[i]) * ht + DL[i];
        case (s)
            0:       return mx[i];
            1:       return my[i];
            2:       return (mx[i] < HA[i] && my[i] < VA[i]) ? 1 : 0;
            3:       return (mx[i] == 0) ? 1 : 0;
            4:       return (mx[i] == 0 && my[i] == 0) ? 1 : 0;
            5:       return (mx[i] >= hlo && mx[i] < hlo + HSY[i]) ? 0 : 1;
            6:       return (p >= vlo && p < vlo + VSY[i] * ht) ? 0 : 1;
            default: return mfc[i];
        endcase
    endfunction

    task automatic model_step(int unsigned i);
        int unsigned ht = HA[i] + HFP[i] + HSY[i] + HBP[i];
        int unsigned vt = VA[i] + VFP[i] + VSY[i] + VBP[i];
        if (rst[i]) begin
            mx[i] = 0;
            my[i] = 0;
            mfc[i] = 0;
        end else if (mx[i] == ht - 1) begin
            mx[i] = 0;
            if (my[i] == vt - 1) begin
                my[i] = 0;
                mfc[i] = (mfc[i] + 1) % 256;
            end else begin
                my[i] = my[i] + 1;
            end
        end else begin
            mx[i] = mx[i] + 1;
        end
    endtask

    task automatic push_all();
        for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned s = 0; s < 8; s++) begin
                exp_q.push_back('{cyc: ncyc + 1, inst: i, sig: s, exp: exp_val(i, s)});
            end
        end
    endtask

    task automatic check(string name, int unsigned act, int unsigned req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pops every expectation due at this sampling point and compares.
    initial begin
        exp_t        e;
        int unsigned act;
        ncyc = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            while (exp_q.size() != 0 && exp_q[0].cyc <= ncyc) begin
                e = exp_q.pop_front();
                act = actual(e.inst, e.sig);
                n_cmp++;
                if (e.cyc != ncyc || act != e.exp) begin
                    n_bad++;
                    $display("FAIL %s.%s @%0d: got %0d, required %0d", inst_name[e.inst],
                             sig_name[e.sig], e.cyc, act, e.exp);
                end
                if (e.inst == 1) begin
                    if (e.sig == 4 && act == 1) tiny_fs++;
                    if (e.sig == 2 && act == 1) tiny_blank++;
                    if (e.sig == 5 && act == 0) tiny_hs_lo++;
                    if (e.sig == 6 && act == 0) tiny_vs_lo++;
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tiny_fs = 0;
        tiny_blank = 0;
        tiny_hs_lo = 0;
        tiny_vs_lo = 0;
        def_done = 1'b0;
        mid_done = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            mx[i] = 0;
            my[i] = 0;
            mfc[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        push_all();
        for (int unsigned i = 0; i < 3; i++) rst[i] = 1'b0;

        for (int unsigned c = 1; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            for (int unsigned i = 0; i < 3; i++) model_step(i);
            push_all();
            // One-cycle resets: default raster inside hsync, mid raster inside both syncs
            rst[0] = !def_done && mx[0] == 700 && my[0] == 1;
            if (rst[0]) def_done = 1'b1;
            rst[2] = !mid_done && mfc[2] == 1 && mx[2] == 13 && my[2] == 5;
            if (rst[2]) mid_done = 1'b1;
        end

        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        check("def_reset_fired", 32'(def_done), 1);
        check("mid_reset_fired", 32'(mid_done), 1);
        check("tiny_frame_starts", tiny_fs, 257);
        check("tiny_blank_cycles", tiny_blank, 257 * 32);
        check("tiny_hs_low_cycles", tiny_hs_lo, 257 * 7 * 4);
        check("tiny_vs_low_cycles", tiny_vs_lo, 257 * 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator driving the pixel pipeline of the tank game display. It produces the DrawX/DrawY/blank stream consumed by the sprite ROM renderers and generates the matching active-low hsync/vsync. The syncs are delayed by a programmable pipeline so they stay aligned with colour that emerges from the renderers' ROM and colour registers. It sits between the pixel clock and every sprite/background renderer, and it drives the VGA/HDMI encoder sync pins.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync pulse width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vsync pulse width, in lines
- V_BP, 33: vertical back porch, in lines
- SYNC_DELAY, 2: pipeline stages applied to hs/vs; legal range 0..4

Ports:
- vga_clk, input, 1: pixel clock; the single clock for the block
- reset, input, 1: synchronous, active-high reset
- DrawX, output, 10: current horizontal count, 0..H_TOTAL-1
- DrawY, output, 10: current vertical count, 0..V_TOTAL-1
- blank, output, 1: 1 = active video (DrawX < H_ACTIVE and DrawY < V_ACTIVE); 0 = blanking
- line_start, output, 1: 1 when DrawX == 0
- frame_start, output, 1: 1 when DrawX == 0 and DrawY == 0
- hs, output, 1: active-low hsync, delayed by SYNC_DELAY cycles
- vs, output, 1: active-low vsync, delayed by SYNC_DELAY cycles
- frame_count, output, 8: completed-frame counter; wraps

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024; a violation is an elaboration error.
- Horizontal counter hc:
  - increments every cycle;
  - at H_TOTAL-1 it wraps to 0.
- Vertical counter vc:
  - increments only on cycles where hc wraps;
  - at V_TOTAL-1 (with hc wrapping) it wraps to 0.
- DrawX = hc and DrawY = vc, driven directly from the counter registers.
- blank, line_start and frame_start are combinational decodes of the current hc/vc, so they are aligned with DrawX/DrawY with no added latency.
- Raw sync decode:
  - hs_raw = 0 iff H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC (656..751);
  - vs_raw = 0 iff V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC (490..491).
- Sync pipeline: hs/vs pass through a SYNC_DELAY-deep shift register. When SYNC_DELAY = 0, hs = hs_raw and vs = vs_raw combinationally.
- frame_count increments by 1 on the cycle where hc == H_TOTAL-1 and vc == V_TOTAL-1; it wraps 255 → 0.
- The block has no enable and no stall: it free-runs.

## Timing
- Reset values, in the cycle after reset is sampled high:
  - hc = 0, vc = 0, so DrawX = 0, DrawY = 0, blank = 1, line_start = 1, frame_start = 1;
  - every sync pipeline stage = 1, so hs = 1 and vs = 1;
  - frame_count = 0.
- Reset asserted mid-frame: all of the above take effect on the next edge. The pipeline is flushed to 1, so no partial sync pulse is emitted after reset.
- First cycle after reset deasserts: counters advance and DrawX = 1 on that edge.
- hsync, with SYNC_DELAY = D: hs is low for exactly H_SYNC consecutive cycles, starting D cycles after DrawX first reads 656.
- vsync: vs is low for exactly V_SYNC × H_TOTAL cycles (1600), starting D cycles after (DrawX, DrawY) = (0, 490).
- Line wrap: the cycle after (799, y) is (0, y+1).
- Frame wrap: the cycle after (799, 524) is (0, 0), with frame_start = 1 and frame_count already incremented.
- blank transitions:
  - 1→0 on the cycle DrawX becomes 640;
  - 0→1 when DrawX becomes 0 on lines 0..479;
  - stays 0 for the whole of lines 480..524.
- Frame period: 420000 cycles exactly.

## Test plan
- Reset then release; sample each cycle → DrawX/DrawY sequence 0,0 → 1,0 → … → 799,0 → 0,1. hs and vs stay 1 for the first 656+D cycles.
- Default parameters, D = 2, one full line → hs low during the cycles where the delayed DrawX is 658..753 (96 cycles). blank low for DrawX 640..799 (160 cycles).
- One full frame → frame_start high exactly once per 420000 cycles. vs low for 1600 cycles beginning 2 cycles after (0, 490). frame_count increments from 0 to 1 at the wrap to (0, 0).
- Assert reset for 1 cycle at (700, 491), i.e. during both syncs → the next cycle shows DrawX = 0, DrawY = 0, hs = 1, vs = 1, frame_count = 0, with no sync glitch thereafter until 656+D.
- Run 256 frames → frame_count wraps 255 → 0. Check blank count per frame = 307200 cycles.
- Re-parameterise with SYNC_DELAY = 0 and an 8/2/4/2 × 4/1/1/1 tiny raster → hs coincident with the raw decode. H_TOTAL = 16 and V_TOTAL = 7 wrap correctly.
